// File: rtl/rast_pkg.sv
// ---------------------------------------------------------------------------
// rast_pkg
//   Types and constants shared along the rasterizer triangle interface,
//   plus the mesh image that the feeder's ROM serves.
//   - COORD_W          : coordinate width (9 bits)
//   - vert_t           : one vertex, [X_IDX]=x, [Y_IDX]=y, [Z_IDX]=z
//   - tri_t            : {v1, v2, v3}, v1 in the MSBs (81 bits)
//   - state_t          : feeder FSM states
//   - mesh_vert/word   : mesh ROM contents as a function of triangle index
// ---------------------------------------------------------------------------
package rast_pkg;

    localparam int COORD_W = 9;
    localparam int X_IDX   = 2;
    localparam int Y_IDX   = 1;
    localparam int Z_IDX   = 0;
    localparam int TRI_W   = 9 * COORD_W;

    typedef logic [2:0][COORD_W-1:0] vert_t;

    typedef struct packed {
        vert_t v1;
        vert_t v2;
        vert_t v3;
    } tri_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_XFORM,
        S_OFFER
    } state_t;

    // Mesh image: x/y stay on-screen (<240) so an unshifted frame is sent
    // verbatim; triangle 0 vertex 1 sits near the bottom-right corner so
    // that small offsets already push it into the clamp.
    function automatic vert_t mesh_vert(input int unsigned tri_idx, input int unsigned k);
        vert_t v;
        v[X_IDX] = COORD_W'((200 + 61 * tri_idx + 13 * k) % 240);
        v[Y_IDX] = COORD_W'((230 + 29 * tri_idx + 71 * k) % 240);
        v[Z_IDX] = COORD_W'((17 + 43 * tri_idx + 11 * k) % 512);
        return v;
    endfunction

    function automatic tri_t mesh_word(input int unsigned tri_idx);
        tri_t t;
        t.v1 = mesh_vert(tri_idx, 0);
        t.v2 = mesh_vert(tri_idx, 1);
        t.v3 = mesh_vert(tri_idx, 2);
        return t;
    endfunction

endpackage

// File: rtl/tri_feeder_rom.sv
// ---------------------------------------------------------------------------
// xilinx_true_dual_port_read_first_2_clock_ram
//   Mesh ROM in the shape of the Xilinx dual-clock BRAM template with the
//   output register enabled (2-cycle read latency). The contents are the
//   constant mesh image from rast_pkg, so both ports are read-only.
//   Ports (per port a/b):
//     clk*    clock              addr*   read address
//     en*     array read enable  rst*    sync clear of output register
//     regce*  output reg enable  dout*   read data (2 cycles after addr)
// ---------------------------------------------------------------------------
module xilinx_true_dual_port_read_first_2_clock_ram
    import rast_pkg::*;
#(
    parameter int RAM_WIDTH = 81,
    parameter int RAM_DEPTH = 12,
    parameter int ADDR_W    = 4
) (
    input  logic                 clka,
    input  logic [ADDR_W-1:0]    addra,
    input  logic                 ena,
    input  logic                 rsta,
    input  logic                 regcea,
    output logic [RAM_WIDTH-1:0] douta,
    input  logic                 clkb,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic                 enb,
    input  logic                 rstb,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] ram_a_p0;
    logic [RAM_WIDTH-1:0] ram_b_p0;

    // array read stage
    always_ff @(posedge clka) begin
        if (ena) begin
            ram_a_p0 <= RAM_WIDTH'(mesh_word(32'(addra)));
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            ram_b_p0 <= RAM_WIDTH'(mesh_word(32'(addrb)));
        end
    end

    // output register stage
    always_ff @(posedge clka) begin
        if (rsta) begin
            douta <= '0;
        end else if (regcea) begin
            douta <= ram_a_p0;
        end
    end

    always_ff @(posedge clkb) begin
        if (rstb) begin
            doutb <= '0;
        end else if (regceb) begin
            doutb <= ram_b_p0;
        end
    end

endmodule

// File: rtl/tri_feeder_xform.sv
// ---------------------------------------------------------------------------
// vert_xform
//   Offsets one vertex by the frame's screen translation and clamps it to
//   the visible area; z passes through. The output register loads only
//   while en is high, so it holds the offered vertex stable otherwise.
//   Ports:
//     clk_in, rst_n_in  clock, asynchronous active-low reset
//     en                load the transformed vertex
//     v_in              raw vertex from the mesh ROM
//     x_off, y_off      latched frame offsets
//     v_out             registered, clamped vertex
// ---------------------------------------------------------------------------
module vert_xform
    import rast_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 240
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               en,
    input  vert_t              v_in,
    input  logic [COORD_W-1:0] x_off,
    input  logic [COORD_W-1:0] y_off,
    output vert_t              v_out
);

    // Sum in COORD_W+1 bits so a wrapped 9-bit result can never slip under
    // the limit.
    function automatic logic [COORD_W-1:0] add_clamp(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b,
        input int unsigned        lim
    );
        logic [COORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > (COORD_W + 1)'(lim)) begin
            return COORD_W'(lim);
        end
        return sum[COORD_W-1:0];
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v_out <= '0;
        end else if (en) begin
            v_out[X_IDX] <= add_clamp(v_in[X_IDX], x_off, WIDTH - 1);
            v_out[Y_IDX] <= add_clamp(v_in[Y_IDX], y_off, HEIGHT - 1);
            v_out[Z_IDX] <= v_in[Z_IDX];
        end
    end

endmodule

// File: rtl/tri_feeder.sv
// ---------------------------------------------------------------------------
// tri_feeder
//   Source end of the rasterizer triangle interface. Each frame it walks the
//   mesh ROM, offsets/clamps every triangle and offers it with valid_tri
//   until the rasterizer accepts it (valid_tri && ready_in).
//   Ports:
//     clk_in, rst_n_in   clock, asynchronous active-low reset
//     new_frame          1-cycle request to send the mesh
//     x_off, y_off       screen offset, latched at frame start
//     ready_in           rasterizer ready
//     vert1..vert3       offered triangle vertices
//     valid_tri          triangle valid
//     obj_done           offered triangle is the last of the mesh
//     busy               frame in progress
//     frame_drop         pulse: request discarded, one already pending
// ---------------------------------------------------------------------------
module tri_feeder
    import rast_pkg::*;
#(
    parameter int NUM_TRIS = 12,
    parameter int WIDTH    = 240,
    parameter int HEIGHT   = 240
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               new_frame,
    input  logic [COORD_W-1:0] x_off,
    input  logic [COORD_W-1:0] y_off,
    input  logic               ready_in,
    output vert_t              vert1,
    output vert_t              vert2,
    output vert_t              vert3,
    output logic               valid_tri,
    output logic               obj_done,
    output logic               busy,
    output logic               frame_drop
);

    localparam int IDX_W = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRIS - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               pending;
    logic               wait_cnt;
    logic [COORD_W-1:0] x_off_q;
    logic [COORD_W-1:0] y_off_q;
    tri_t               rom_word;
    logic               xform_en;

    // The ROM address follows idx directly; idx only moves on frame start
    // or a transfer, so the word is settled by the time XFORM samples it.
    xilinx_true_dual_port_read_first_2_clock_ram #(
        .RAM_WIDTH (TRI_W),
        .RAM_DEPTH (NUM_TRIS),
        .ADDR_W    (IDX_W)
    ) u_mesh_rom (
        .clka   (clk_in),
        .addra  (idx),
        .ena    (1'b1),
        .rsta   (1'b0),
        .regcea (1'b1),
        .douta  (rom_word),
        .clkb   (clk_in),
        .addrb  ('0),
        .enb    (1'b0),
        .rstb   (1'b0),
        .regceb (1'b0),
        .doutb  ()
    );

    assign xform_en = (state == S_XFORM);

    vert_xform #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_xform_v1 (
        .clk_in (clk_in), .rst_n_in (rst_n_in), .en (xform_en),
        .v_in (rom_word.v1), .x_off (x_off_q), .y_off (y_off_q), .v_out (vert1)
    );

    vert_xform #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_xform_v2 (
        .clk_in (clk_in), .rst_n_in (rst_n_in), .en (xform_en),
        .v_in (rom_word.v2), .x_off (x_off_q), .y_off (y_off_q), .v_out (vert2)
    );

    vert_xform #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_xform_v3 (
        .clk_in (clk_in), .rst_n_in (rst_n_in), .en (xform_en),
        .v_in (rom_word.v3), .x_off (x_off_q), .y_off (y_off_q), .v_out (vert3)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= S_IDLE;
            idx        <= '0;
            pending    <= 1'b0;
            wait_cnt   <= 1'b0;
            x_off_q    <= '0;
            y_off_q    <= '0;
            valid_tri  <= 1'b0;
            obj_done   <= 1'b0;
            busy       <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= 1'b0;

            // Requests during a frame queue one deep; a further one is lost.
            if (state != S_IDLE && new_frame) begin
                if (pending) begin
                    frame_drop <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (pending || new_frame) begin
                        x_off_q <= x_off;
                        y_off_q <= y_off;
                        idx     <= '0;
                        busy    <= 1'b1;
                        // Starting from pending while a fresh request
                        // arrives: the fresh one becomes the new pending.
                        pending <= pending & new_frame;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    wait_cnt <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt) begin
                        state <= S_XFORM;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end
                S_XFORM: begin
                    valid_tri <= 1'b1;
                    obj_done  <= (idx == LAST_IDX);
                    state     <= S_OFFER;
                end
                S_OFFER: begin
                    if (ready_in) begin
                        valid_tri <= 1'b0;
                        obj_done  <= 1'b0;
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
